// File: rtl/mem_access_unit.sv
// Single-port memory access unit: services one processor request at a time
// against a block RAM (1-cycle read latency) and a small memory-mapped IO window.
module mem_access_unit #(
    parameter int unsigned RAM_WORDS   = 1024,
    parameter logic [15:0] IO_IN_ADDR  = 16'hFFFE,
    parameter logic [15:0] IO_OUT_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wea,
    output logic [9:0]  mem_addra,
    output logic [15:0] mem_dina,
    input  logic [15:0] mem_douta,
    input  logic [15:0] io_in,
    output logic [15:0] io_out,
    output logic [15:0] txn_count
);

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned MAW = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [DW-1:0]   wdata_q;

    logic            accept_c;
    logic            req_ram_c;
    logic            req_io_c;
    logic [DW-1:0]   acc_rdata_c;
    logic            acc_err_c;
    logic            acc_io_out_we_c;

    function automatic logic is_ram(input logic [AW-1:0] a);
        return (32'(a) < RAM_WORDS);
    endfunction

    // Accept-time decode and next-state selection
    always_comb begin
        state_next      = state;
        accept_c        = 1'b0;
        req_ram_c       = is_ram(req_addr);
        req_io_c        = (req_addr == IO_IN_ADDR) || (req_addr == IO_OUT_ADDR);
        acc_rdata_c     = '0;
        acc_err_c       = 1'b0;
        acc_io_out_we_c = 1'b0;

        if (!req_ram_c && !req_we) begin
            if (req_addr == IO_IN_ADDR) begin
                acc_rdata_c = io_in;
            end else if (req_addr == IO_OUT_ADDR) begin
                acc_rdata_c = io_out;
            end
        end

        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c        = 1'b1;
                    acc_err_c       = !req_ram_c && !req_io_c;
                    acc_io_out_we_c = !req_ram_c && req_we && (req_addr == IO_OUT_ADDR);
                    state_next      = req_ram_c ? ISSUE : RESP;
                end
            end
            ISSUE:   state_next = we_q ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            io_out     <= '0;
            txn_count  <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state      <= state_next;
            req_ready  <= (state_next == IDLE);
            resp_valid <= (state_next == RESP);
            if (accept_c) begin
                addr_q     <= req_addr;
                we_q       <= req_we;
                wdata_q    <= req_wdata;
                resp_rdata <= acc_rdata_c;
                resp_err   <= acc_err_c;
                if (acc_io_out_we_c) begin
                    io_out <= req_wdata;
                end
            end
            // RAM output is registered, so it is valid during WAIT
            if (state == WAIT) begin
                resp_rdata <= mem_douta;
            end
            if (state == RESP) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

    // Reset must kill a pending RAM write in the very cycle it is raised
    assign mem_wea   = (state == ISSUE) && we_q && is_ram(addr_q) && !reset;
    assign mem_addra = addr_q[MAW-1:0];
    assign mem_dina  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses; a negedge monitor pops and checks data, error flag and latency.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_wea;
    logic [9:0]  mem_addra;
    logic [15:0] mem_dina;
    logic [15:0] mem_douta;
    logic [15:0] io_in = 16'h5A5A;
    logic [15:0] io_out;
    logic [15:0] txn_count;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wea    (mem_wea),
        .mem_addra  (mem_addra),
        .mem_dina   (mem_dina),
        .mem_douta  (mem_douta),
        .io_in      (io_in),
        .io_out     (io_out),
        .txn_count  (txn_count)
    );

    always #5 clk = ~clk;

    // Block RAM model: read-first, registered output; preloaded once at start
    logic [15:0] ram [0:1023];
    logic        preload_done = 1'b0;
    always @(posedge clk) begin
        if (!preload_done) begin
            ram[2]       <= 16'h0202;
            ram[5]       <= 16'h1111;
            preload_done <= 1'b1;
        end else if (mem_wea) begin
            ram[mem_addra] <= mem_dina;
        end
        mem_douta <= ram[mem_addra];
    end

    int cyc = 0;
    int wea_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wea) wea_cnt <= wea_cnt + 1;
    end

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp got resp_valid=1 expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 16'(resp_err), 16'(e.err));
                chk("latency", 16'(cyc - e.acc), 16'(e.lat));
            end
        end
    end

    // Issues one request and returns at the accept edge; req_valid stays high
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata_e, input logic err_e, input int lat_e);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got req_ready=0 expected 1 addr=%h", addr);
            req_valid = 1'b0;
            return;
        end
        e.rdata = rdata_e;
        e.err   = err_e;
        e.lat   = lat_e;
        e.acc   = cyc;
        sb.push_back(e);
        acc_q.push_back(cyc);
        @(posedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int w0;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 16'(req_ready), 16'd1);
        chk("rst_resp_valid", 16'(resp_valid), 16'd0);
        chk("rst_resp_err", 16'(resp_err), 16'd0);
        chk("rst_resp_rdata", resp_rdata, 16'h0000);
        chk("rst_io_out", io_out, 16'h0000);
        chk("rst_txn", txn_count, 16'h0000);
        chk("rst_wea", 16'(mem_wea), 16'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 16'(req_ready), 16'd1);

        // Basic RAM write then read
        w0 = wea_cnt;
        do_req(1'b1, 16'h0000, 16'hDEAD, 16'h0000, 1'b0, 2);
        do_req(1'b0, 16'h0000, 16'h0000, 16'hDEAD, 1'b0, 3);
        drain();
        chk("wea_pulses_1", 16'(wea_cnt - w0), 16'd1);

        // Address extremes, no aliasing, preloaded word untouched
        w0 = wea_cnt;
        do_req(1'b1, 16'h0001, 16'hBEEF, 16'h0000, 1'b0, 2);
        do_req(1'b1, 16'h03FF, 16'hABCD, 16'h0000, 1'b0, 2);
        do_req(1'b0, 16'h0001, 16'h0000, 16'hBEEF, 1'b0, 3);
        do_req(1'b0, 16'h03FF, 16'h0000, 16'hABCD, 1'b0, 3);
        do_req(1'b0, 16'h0002, 16'h0000, 16'h0202, 1'b0, 3);
        drain();
        chk("wea_pulses_2", 16'(wea_cnt - w0), 16'd2);

        // IO window
        w0 = wea_cnt;
        do_req(1'b1, 16'hFFFF, 16'h1234, 16'h0000, 1'b0, 1);
        @(negedge clk);
        chk("io_out_at_resp", io_out, 16'h1234);
        do_req(1'b0, 16'hFFFE, 16'h0000, 16'h5A5A, 1'b0, 1);
        do_req(1'b0, 16'hFFFF, 16'h0000, 16'h1234, 1'b0, 1);
        do_req(1'b1, 16'hFFFE, 16'h9999, 16'h0000, 1'b0, 1);
        drain();
        chk("io_out_kept", io_out, 16'h1234);

        // Unmapped accesses
        do_req(1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1);
        do_req(1'b1, 16'h8000, 16'h5555, 16'h0000, 1'b1, 1);
        drain();
        chk("wea_none_io_unmapped", 16'(wea_cnt - w0), 16'd0);
        chk("io_out_unmapped", io_out, 16'h1234);
        chk("txn_13", txn_count, 16'h000D);

        // Reset during ISSUE of a RAM write
        w0 = wea_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0005;
        req_wdata = 16'h7777;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("wea_in_reset", 16'(mem_wea), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("ready_post_abort", 16'(req_ready), 16'd1);
        @(negedge clk);
        chk("wea_abort", 16'(wea_cnt - w0), 16'd0);
        chk("txn_abort", txn_count, 16'h0000);
        do_req(1'b0, 16'h0005, 16'h0000, 16'h1111, 1'b0, 3);
        drain();

        // Back-to-back reads with req_valid held
        do_reset();
        acc_q.delete();
        do_req(1'b0, 16'h0000, 16'h0000, 16'hDEAD, 1'b0, 3);
        do_req(1'b0, 16'h0001, 16'h0000, 16'hBEEF, 1'b0, 3);
        do_req(1'b0, 16'h0002, 16'h0000, 16'h0202, 1'b0, 3);
        drain();
        if (acc_q.size() == 3) begin
            chk("b2b_accept_1", 16'(acc_q[1] - acc_q[0]), 16'd4);
            chk("b2b_accept_2", 16'(acc_q[2] - acc_q[0]), 16'd8);
        end else begin
            chk("b2b_accepts", 16'(acc_q.size()), 16'd3);
        end
        chk("txn_3", txn_count, 16'h0003);

        // Counter wrap from a preset value
        @(negedge clk);
        force dut.txn_count = 16'hFFFF;
        @(negedge clk);
        release dut.txn_count;
        @(negedge clk);
        chk("txn_preset", txn_count, 16'hFFFF);
        do_req(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1);
        drain();
        chk("txn_wrap", txn_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter RAM_WORDS, default 1024, SHALL set the number of RAM words, mapped at 0x0000..RAM_WORDS-1.
REQ-003 Parameter IO_IN_ADDR, default 16'hFFFE, SHALL be the read-only input port address.
REQ-004 Parameter IO_OUT_ADDR, default 16'hFFFF, SHALL be the read/write output register address.
REQ-005 Ports SHALL be:
clk  in  1  clock
reset  in  1  sync active-high reset
req_valid  in  1  processor request present
req_we  in  1  1=write, 0=read
req_addr  in  16  word address
req_wdata  in  16  write data
req_ready  out  1  request accepted this cycle when high with req_valid
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  16  read data, valid with resp_valid
resp_err  out  1  unmapped address, valid with resp_valid
mem_wea  out  1  block RAM write enable
mem_addra  out  10  block RAM address
mem_dina  out  16  block RAM write data
mem_douta  in  16  block RAM read data (registered, 1-cycle latency)
io_in  in  16  external input port
io_out  out  16  output register
txn_count  out  16  completed-transaction counter

Function
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-007 req_ready SHALL be high exactly when state is IDLE; req_valid outside IDLE SHALL be ignored.
REQ-008 Accept (IDLE, req_valid=1) SHALL register req_we, req_addr and req_wdata into addr_q, we_q and wdata_q.
REQ-009 Decode: addr_q < RAM_WORDS is RAM; addr_q = IO_IN_ADDR or IO_OUT_ADDR is IO; any other address is unmapped.
REQ-010 RAM read path SHALL be IDLE->ISSUE->WAIT->RESP: ISSUE drives mem_addra=addr_q[9:0] with mem_wea=0, and WAIT captures mem_douta at its closing edge.
REQ-011 RAM write path SHALL be IDLE->ISSUE->RESP, with ISSUE driving mem_wea=1, mem_addra=addr_q[9:0] and mem_dina=wdata_q.
REQ-012 IO and unmapped requests SHALL go IDLE->RESP directly.
REQ-013 resp_valid SHALL be high only in RESP, for exactly one cycle, and RESP->IDLE SHALL be unconditional; there is no response back-pressure.
REQ-014 Latency from accept cycle to resp_valid SHALL be 3 cycles for RAM read, 2 for RAM write, and 1 for IO or unmapped.
REQ-015 resp_rdata SHALL be: captured mem_douta for RAM reads; io_in sampled at the accept edge for an IO_IN_ADDR read; io_out for an IO_OUT_ADDR read; 0 for writes and unmapped accesses.
REQ-016 A write to IO_OUT_ADDR SHALL update io_out at the edge entering RESP; a write to IO_IN_ADDR SHALL be ignored without error.
REQ-017 resp_err SHALL be 1 with resp_valid for unmapped accesses only; unmapped writes SHALL alter nothing.
REQ-018 mem_wea SHALL be high only in ISSUE with we_q=1 and reset=0, gated combinationally so that reset suppresses it in the same cycle.
REQ-019 mem_addra and mem_dina SHALL follow addr_q[9:0] and wdata_q in all states.
REQ-020 txn_count SHALL increment by 1 on every RESP cycle, including error responses, and wrap 0xFFFF->0x0000.
REQ-021 Back-to-back requests: the next accept SHALL occur no earlier than the cycle after RESP.

Reset
REQ-022 While reset is high at an edge: state->IDLE, resp_valid=0, resp_rdata=0, resp_err=0, io_out=0, txn_count=0, addr_q=0, we_q=0, wdata_q=0.
REQ-023 Reset mid-transaction SHALL abandon the transaction: no resp_valid is produced and no RAM write occurs in or after the reset cycle.
REQ-024 req_ready SHALL be high in the first cycle after reset deasserts.

Verification
REQ-025 Reset, write 0xDEAD to 0x0000, then read 0x0000 -> mem_wea high for exactly one cycle; read resp_valid 3 cycles after accept with resp_rdata=0xDEAD and resp_err=0.
REQ-026 Write 0xBEEF to 0x0001 and 0xABCD to 0x03FF, then read 0x0001 and 0x03FF -> 0xBEEF and 0xABCD with no aliasing; read of 0x0002 returns its preloaded value unchanged.
REQ-027 Write 0x1234 to 0xFFFF -> io_out=0x1234 at the resp cycle (latency 1); with io_in=0x5A5A, read 0xFFFE -> 0x5A5A; write 0x9999 to 0xFFFE -> resp_err=0 and no state change.
REQ-028 Read 0x0400 -> latency 1, resp_rdata=0, resp_err=1; write 0x8000 -> resp_err=1, and mem_wea never asserts.
REQ-029 Assert reset during ISSUE of a 0x7777 write to 0x0005 (prior value 0x1111) -> mem_wea=0 that cycle and no resp_valid; a later read of 0x0005 returns 0x1111.
REQ-030 Hold req_valid high for 3 consecutive RAM reads -> accepts at cycles 0, 4 and 8 relative to the first accept; txn_count goes 0->3; preset txn_count 0xFFFF wraps to 0x0000.
